main_ram_ctrl: RTL

//  Synchronous master for the asynchronous main RAM (_cs/_oe/_w strobes, 20-bit addr, 8-bit data).

---
 rtl/main_ram_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/main_ram_ctrl.sv
// Synchronous master for asynchronous main RAM: registered, glitch-free _cs/_oe/_w strobe sequences.
// Latency: ack in cycle WAIT+2 after the accepting edge (write WR_WAIT+RD_WAIT+4 with MAIN_RAM_CTRL_VERIFY_EN).
// Backpressure: req is sampled only in IDLE and never queued; busy is high whenever a transaction is in flight.
module main_ram_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              verify_err,
    output logic              _ram_cs,
    output logic              _ram_oe,
    output logic              _ram_w,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       is_wr;
`ifdef MAIN_RAM_CTRL_VERIFY_EN
    logic       vfy;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            is_wr      <= 1'b0;
            rdata      <= '0;
            ack        <= 1'b0;
            verify_err <= 1'b0;
            _ram_cs    <= 1'b1;
            _ram_oe    <= 1'b1;
            _ram_w     <= 1'b1;
            ram_addr   <= '0;
            ram_wdata  <= '0;
`ifdef MAIN_RAM_CTRL_VERIFY_EN
            vfy        <= 1'b0;
`endif
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state      <= SETUP;
                        ram_addr   <= addr;
                        ram_wdata  <= wdata;
                        is_wr      <= we;
                        cnt        <= we ? 4'(WR_WAIT) : 4'(RD_WAIT);
                        _ram_cs    <= 1'b0;
                        verify_err <= 1'b0;
`ifdef MAIN_RAM_CTRL_VERIFY_EN
                        vfy        <= 1'b0;
`endif
                    end
                end
                SETUP: begin
                    state <= STROBE;
`ifdef MAIN_RAM_CTRL_VERIFY_EN
                    if (is_wr && !vfy) _ram_w  <= 1'b0;
                    else               _ram_oe <= 1'b0;
`else
                    if (is_wr) _ram_w  <= 1'b0;
                    else       _ram_oe <= 1'b0;
`endif
                end
                STROBE: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state   <= HOLD;
                        _ram_w  <= 1'b1;
                        _ram_oe <= 1'b1;
                        // The verify read-back must not disturb the requester's read data.
                        if (!is_wr) rdata <= ram_rdata;
`ifdef MAIN_RAM_CTRL_VERIFY_EN
                        if (vfy) verify_err <= (ram_rdata != ram_wdata);
                        ack <= !(is_wr && !vfy);
`else
                        ack <= 1'b1;
`endif
                    end
                end
                HOLD: begin
`ifdef MAIN_RAM_CTRL_VERIFY_EN
                    if (is_wr && !vfy) begin
                        // Chain straight into the read-back; _cs stays low, address is unchanged.
                        vfy   <= 1'b1;
                        cnt   <= 4'(RD_WAIT);
                        state <= SETUP;
                    end else begin
                        state   <= IDLE;
                        _ram_cs <= 1'b1;
                    end
`else
                    state   <= IDLE;
                    _ram_cs <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
